// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage (package if_pkg).
package if_pkg;

    localparam int INSTR_BYTES = 4;

    // TRAP is only reachable when IF_MISALIGN_TRAP_EN is defined.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        TRAP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Memory request/response and decode-side valid/ready bundle of the fetch stage.
interface instr_fetch_if #(
    parameter int WordSize = 32
);

    logic                imem_req_valid;
    logic [WordSize-1:0] imem_req_addr;
    logic                imem_req_ready;
    logic                imem_resp_valid;
    logic [WordSize-1:0] imem_resp_data;
    logic                if_valid;
    logic [WordSize-1:0] if_pc;
    logic [WordSize-1:0] if_instr;
    logic                if_ready;

    // master: the fetch stage; slave: memory plus decode.
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_valid, if_pc, if_instr,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_valid, if_pc, if_instr,
        output if_ready
    );

endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues one request at a time, presents results to decode.
// Optional misaligned-target trap compiled in with `define IF_MISALIGN_TRAP_EN.
module instr_fetch
    import if_pkg::*;
#(
    parameter int                  WordSize    = 32,
    parameter logic [WordSize-1:0] ResetVector = '0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                redirect,
    input  logic [WordSize-1:0] redirect_addr,
    input  logic                stall,
    instr_fetch_if.master       bus
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic                misaligned
`endif
);

    fetch_state_t        state;
    logic [WordSize-1:0] pc;
    logic [WordSize-1:0] req_pc;
    logic                kill;

    logic                req_fire;
    logic [WordSize-1:0] target;
    fetch_state_t        flush_state;   // where a redirect lands once nothing is in flight
    fetch_state_t        resume_state;  // where a killed response lands

    assign bus.imem_req_valid = (state == REQ) && !stall && !redirect;
    assign bus.imem_req_addr  = pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

`ifdef IF_MISALIGN_TRAP_EN
    logic target_misaligned;

    assign target_misaligned = |redirect_addr[1:0];
    assign target            = redirect_addr;
    assign flush_state       = target_misaligned ? TRAP : REQ;
    // misaligned already reflects the latest redirect by the time a killed response returns.
    assign resume_state      = misaligned ? TRAP : REQ;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            misaligned <= 1'b0;
        end else if (redirect) begin
            misaligned <= target_misaligned;
        end
    end
`else
    assign target       = redirect_addr & ~WordSize'(INSTR_BYTES - 1);
    assign flush_state  = REQ;
    assign resume_state = REQ;
`endif

    // NOTE: reset is synchronous, so it is the first branch inside the clocked block, and all
    // state uses non-blocking assignments so each register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= REQ;
            pc           <= ResetVector;
            req_pc       <= '0;
            kill         <= 1'b0;
            bus.if_valid <= 1'b0;
            bus.if_pc    <= '0;
            bus.if_instr <= '0;
        end else if (redirect) begin
            pc           <= target;
            bus.if_valid <= 1'b0;
            // A response still owed by memory must be swallowed before the new target is fetched.
            if (state == WAIT && !bus.imem_resp_valid) begin
                kill <= 1'b1;
            end else begin
                kill  <= 1'b0;
                state <= flush_state;
            end
        end else begin
            case (state)
                REQ: begin
                    if (req_fire) begin
                        req_pc <= pc;
                        pc     <= pc + WordSize'(INSTR_BYTES);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= resume_state;
                        end else begin
                            bus.if_pc    <= req_pc;
                            bus.if_instr <= bus.imem_resp_data;
                            bus.if_valid <= 1'b1;
                            state        <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.if_ready) begin
                        bus.if_valid <= 1'b0;
                        state        <= REQ;
                    end
                end
                default: begin
                    // TRAP: parked until an aligned redirect.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model plus request/instruction scoreboards.
// Build with +define+IF_MISALIGN_TRAP_EN to exercise the trap variant.
module tb_instr_fetch;

    logic        clk;
    logic        rstn;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        stall;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    instr_fetch_if #(.WordSize(32)) bus ();

    instr_fetch #(
        .WordSize   (32),
        .ResetVector(32'h0)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .stall        (stall),
        .bus          (bus)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misaligned   (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int failures  = 0;

    // Memory model: single outstanding request answered mem_lat cycles after acceptance.
    bit          mem_ready;
    bit          mem_busy;
    int          mem_lat;
    int          mem_cnt;
    logic [31:0] mem_addr;

    logic [31:0] req_exp[$];
    logic [31:0] exp_q[$];

    int cyc            = 0;
    int first_req_cyc  = -1;
    int second_req_cyc = -1;
    int first_ifv_cyc  = -1;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // First half of a cycle: drive memory outputs, settle, then log handshakes due at the next edge.
    task automatic begin_cycle();
        logic [31:0] e;
        bus.imem_req_ready  = mem_ready && !mem_busy;
        bus.imem_resp_valid = mem_busy && (mem_cnt == 0);
        bus.imem_resp_data  = (mem_busy && mem_cnt == 0) ? mem_data(mem_addr) : 32'h0;
        #1;
        if (bus.imem_resp_valid) mem_busy = 1'b0;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            if (first_req_cyc < 0) first_req_cyc = cyc;
            else if (second_req_cyc < 0) second_req_cyc = cyc;
            if (req_exp.size() == 0) begin
                check("req_extra", bus.imem_req_addr, 32'hFFFF_FFFF);
            end else begin
                e = req_exp.pop_front();
                check("req_addr", bus.imem_req_addr, e);
            end
            mem_busy = 1'b1;
            mem_addr = bus.imem_req_addr;
            mem_cnt  = mem_lat;
        end
        if (bus.if_valid === 1'b1 && first_ifv_cyc < 0) first_ifv_cyc = cyc;
        if (bus.if_valid && bus.if_ready) begin
            if (exp_q.size() == 0) begin
                check("if_extra", bus.if_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("if_pc", bus.if_pc, e);
                check("if_instr", bus.if_instr, mem_data(e));
            end
        end
    endtask

    task automatic end_cycle();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (mem_busy && mem_cnt > 0) mem_cnt--;
    endtask

    task automatic cycle_go();
        begin_cycle();
        end_cycle();
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles);
        int n = 0;
        while ((req_exp.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
            cycle_go();
            n++;
        end
        check({tag, "_pending"}, req_exp.size() + exp_q.size(), 0);
        req_exp.delete();
        exp_q.delete();
    endtask

    initial begin
        rstn                = 1'b0;
        redirect            = 1'b0;
        redirect_addr       = 32'h0;
        stall               = 1'b0;
        bus.if_ready        = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        mem_ready           = 1'b0;
        mem_busy            = 1'b0;
        mem_lat             = 1;
        mem_cnt             = 0;
        mem_addr            = 32'h0;

        @(negedge clk);
        cycle_go();
        cycle_go();
        rstn = 1'b1;
        #1;
        check("rst_if_valid", bus.if_valid, 0);
        check("rst_if_pc", bus.if_pc, 0);
        check("rst_if_instr", bus.if_instr, 0);
        check("rst_req_valid", bus.imem_req_valid, 1);
        check("rst_req_addr", bus.imem_req_addr, 0);

        // Streaming with k=1.
        mem_ready    = 1'b1;
        bus.if_ready = 1'b1;
        req_exp.push_back(32'h0);
        req_exp.push_back(32'h4);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        run_until_idle("stream", 20);
        check("first_ifv_latency", first_ifv_cyc - first_req_cyc, 2);
        check("req_period", second_req_cyc - first_req_cyc, 3);

        // Redirect while a slow response for 0x8 is pending.
        mem_lat = 3;
        req_exp.push_back(32'h8);
        cycle_go();
        redirect      = 1'b1;
        redirect_addr = 32'h100;
        begin_cycle();
        check("redir_wait_no_req", bus.imem_req_valid, 0);
        end_cycle();
        redirect = 1'b0;
        mem_lat  = 1;
        req_exp.push_back(32'h100);
        exp_q.push_back(32'h100);
        run_until_idle("redir_wait", 20);

        // Redirect on the same cycle as a response.
        req_exp.push_back(32'h104);
        run_until_idle("pre_redir_resp", 10);
        redirect      = 1'b1;
        redirect_addr = 32'h200;
        cycle_go();
        redirect = 1'b0;
        req_exp.push_back(32'h200);
        exp_q.push_back(32'h200);
        begin_cycle();
        check("redir_resp_req_next", bus.imem_req_valid, 1);
        end_cycle();
        run_until_idle("redir_resp", 20);

        // Decode back-pressure: hold for 5 cycles.
        bus.if_ready = 1'b0;
        req_exp.push_back(32'h204);
        run_until_idle("pre_hold", 10);
        cycle_go();
        for (int i = 0; i < 5; i++) begin
            begin_cycle();
            check("hold_if_valid", bus.if_valid, 1);
            check("hold_if_pc", bus.if_pc, 32'h204);
            check("hold_if_instr", bus.if_instr, mem_data(32'h204));
            check("hold_no_req", bus.imem_req_valid, 0);
            end_cycle();
        end
        bus.if_ready = 1'b1;
        exp_q.push_back(32'h204);
        req_exp.push_back(32'h208);
        begin_cycle();
        check("hold_release_no_req", bus.imem_req_valid, 0);
        end_cycle();
        begin_cycle();
        check("hold_next_req", bus.imem_req_valid, 1);
        end_cycle();
        exp_q.push_back(32'h208);
        run_until_idle("hold", 20);

        // Stall in REQ blocks requests and freezes pc; stall in WAIT keeps the response.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            begin_cycle();
            check("stall_req_valid", bus.imem_req_valid, 0);
            check("stall_pc", bus.imem_req_addr, 32'h20C);
            end_cycle();
        end
        stall   = 1'b0;
        mem_lat = 2;
        req_exp.push_back(32'h20C);
        exp_q.push_back(32'h20C);
        cycle_go();
        stall = 1'b1;
        run_until_idle("stall_wait", 20);
        begin_cycle();
        check("stall_after_req_valid", bus.imem_req_valid, 0);
        end_cycle();
        stall   = 1'b0;
        mem_lat = 1;

        // Misaligned redirect target.
        redirect      = 1'b1;
        redirect_addr = 32'h102;
        cycle_go();
        redirect = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            begin_cycle();
            check("trap_misaligned", misaligned, 1);
            check("trap_no_req", bus.imem_req_valid, 0);
            check("trap_if_valid", bus.if_valid, 0);
            end_cycle();
        end
        redirect      = 1'b1;
        redirect_addr = 32'h200;
        cycle_go();
        redirect = 1'b0;
        req_exp.push_back(32'h200);
        exp_q.push_back(32'h200);
        begin_cycle();
        check("trap_cleared", misaligned, 0);
        end_cycle();
        run_until_idle("trap_exit", 20);
`else
        req_exp.push_back(32'h100);
        exp_q.push_back(32'h100);
        run_until_idle("misalign_round", 20);
`endif

        // PC wraps modulo 2^32.
        redirect      = 1'b1;
        redirect_addr = 32'hFFFF_FFFC;
        cycle_go();
        redirect = 1'b0;
        req_exp.push_back(32'hFFFF_FFFC);
        req_exp.push_back(32'h0);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        run_until_idle("wrap", 20);

        // Reset while a response is outstanding; the late response must be ignored.
        mem_lat = 3;
        req_exp.push_back(32'h4);
        run_until_idle("pre_reset", 10);
        rstn      = 1'b0;
        mem_ready = 1'b0;
        cycle_go();
        rstn = 1'b1;
        #1;
        check("mid_rst_if_valid", bus.if_valid, 0);
        check("mid_rst_req_addr", bus.imem_req_addr, 32'h0);
        mem_ready = 1'b1;
        mem_lat   = 1;
        req_exp.push_back(32'h0);
        exp_q.push_back(32'h0);
        run_until_idle("post_reset", 30);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
